// File: rtl/prbs9_checker_pkg.sv
// Shared types, constants and the PRBS9 predictor used by the checker
// and by anything that needs to model the x^9 + x^5 + 1 stream.
package prbs9_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam int PRBS_LEN = 9;
    localparam int TAP_A    = 9;
    localparam int TAP_B    = 5;

    // sr[k] is the bit received k samples ago; result is the next expected bit.
    function automatic logic prbs9_next(input logic [PRBS_LEN:1] sr);
        return sr[TAP_A] ^ sr[TAP_B];
    endfunction

endpackage

// File: rtl/prbs9_checker_if.sv
// Serial link-side bundle between a PRBS9 source/driver and the checker.
interface prbs9_checker_if #(
    parameter int CNT_W = 16
) ();
    logic             en;
    logic             bit_in;
    logic             clr_count;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, bit_in, clr_count,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  en, bit_in, clr_count,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/prbs9_checker.sv
// Self-synchronising PRBS9 receive checker: hunts for a seed, verifies the
// sequence, then free-runs its own prediction and counts bit errors.
module prbs9_checker
    import prbs9_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int WIN_LEN    = 256,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    prbs9_checker_if.slave  link
);

    localparam int SEED_W  = $clog2(PRBS_LEN + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN + 1);
    localparam int WERR_W  = $clog2(ERR_THRESH + 1);

    state_t              state_reg, state_next;
    logic [PRBS_LEN:1]   sr_reg, sr_next;
    logic [SEED_W-1:0]   seed_cnt_reg, seed_cnt_next;
    logic [MATCH_W-1:0]  match_cnt_reg, match_cnt_next;
    logic [WIN_W-1:0]    win_cnt_reg, win_cnt_next;
    logic [WERR_W-1:0]   win_err_reg, win_err_next;
    logic                locked_reg, locked_next;
    logic                err_pulse_reg, err_pulse_next;
    logic [CNT_W-1:0]    err_count_reg, err_count_next;

    logic                predicted;
    logic                mismatch;
    logic [WERR_W-1:0]   win_err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            sr_reg        <= '0;
            seed_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            sr_reg        <= sr_next;
            seed_cnt_reg  <= seed_cnt_next;
            match_cnt_reg <= match_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sr_next        = sr_reg;
        seed_cnt_next  = seed_cnt_reg;
        match_cnt_next = match_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        locked_next    = locked_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;

        predicted   = prbs9_next(sr_reg);
        mismatch    = link.bit_in ^ predicted;
        win_err_inc = win_err_reg + WERR_W'(mismatch);

        if (link.en) begin
            case (state_reg)
                HUNT: begin
                    sr_next       = {sr_reg[PRBS_LEN-1:1], link.bit_in};
                    seed_cnt_next = seed_cnt_reg + 1'b1;
                    if (seed_cnt_reg == SEED_W'(PRBS_LEN - 1)) begin
                        state_next     = VERIFY;
                        match_cnt_next = '0;
                    end
                end

                VERIFY: begin
                    sr_next = {sr_reg[PRBS_LEN-1:1], link.bit_in};
                    if (mismatch) begin
                        match_cnt_next = '0;
                    end else if (sr_reg != '0) begin
                        // An all-zero register trivially predicts zero; such matches prove nothing.
                        match_cnt_next = match_cnt_reg + 1'b1;
                        if (match_cnt_reg == MATCH_W'(LOCK_CNT - 1)) begin
                            state_next   = LOCK;
                            locked_next  = 1'b1;
                            win_cnt_next = '0;
                            win_err_next = '0;
                        end
                    end
                end

                LOCK: begin
                    // Feed back our own prediction so line errors never corrupt the reference.
                    sr_next      = {sr_reg[PRBS_LEN-1:1], predicted};
                    win_cnt_next = win_cnt_reg + 1'b1;
                    win_err_next = win_err_inc;
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != {CNT_W{1'b1}})
                            err_count_next = err_count_reg + 1'b1;
                    end
                    if (win_err_inc >= WERR_W'(ERR_THRESH)) begin
                        state_next    = HUNT;
                        locked_next   = 1'b0;
                        seed_cnt_next = '0;
                    end else if (win_cnt_reg == WIN_W'(WIN_LEN - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end
                end

                default: begin
                    state_next  = HUNT;
                    locked_next = 1'b0;
                end
            endcase
        end

        if (link.clr_count)
            err_count_next = '0;
    end

    assign link.locked    = locked_reg;
    assign link.err_pulse = err_pulse_reg;
    assign link.err_count = err_count_reg;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: lock timing, error counting, burst
// loss of lock, window wrap, gaps, counter clear and degenerate input.
module tb_prbs9_checker;
    import prbs9_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs9_checker_if #(.CNT_W(16)) link ();

    prbs9_checker #(
        .LOCK_CNT  (16),
        .WIN_LEN   (256),
        .ERR_THRESH(8),
        .CNT_W     (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .link (link)
    );

    int tests = 0;
    int fails = 0;

    logic stream [0:1999];
    logic flip   [0:1999];

    int   pulse_cnt, last_pulse, first_rise, last_rise, drop_cnt, drop_at;
    logic prev_locked;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end else begin
            $display("ok   %s: %0d", tag, $signed(got));
        end
    endtask

    task automatic reset_stats();
        pulse_cnt   = 0;
        last_pulse  = -1;
        first_rise  = -1;
        last_rise   = -1;
        drop_cnt    = 0;
        drop_at     = -1;
        prev_locked = link.locked;
    endtask

    task automatic send_bit(input logic b, input int idx);
        link.en     = 1'b1;
        link.bit_in = b;
        @(posedge clk);
        #1;
        link.en = 1'b0;
        if (link.err_pulse) begin
            pulse_cnt++;
            last_pulse = idx;
        end
        if (link.locked && !prev_locked) begin
            if (first_rise < 0) first_rise = idx;
            last_rise = idx;
        end
        if (!link.locked && prev_locked) begin
            drop_cnt++;
            drop_at = idx;
        end
        prev_locked = link.locked;
    endtask

    task automatic run_stream(input int from, input int upto);
        for (int i = from; i <= upto; i++)
            send_bit(stream[i] ^ flip[i], i);
    endtask

    task automatic idle(input int n);
        link.en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        link.en        = 1'b0;
        link.bit_in    = 1'b0;
        link.clr_count = 1'b0;
        for (int i = 0; i < 2000; i++) flip[i] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_stats();
    endtask

    initial begin
        logic [PRBS_LEN:1] sr;
        int base;

        // Reference stream from seed 9'h1FF: b[n] = b[n-9] ^ b[n-5]
        for (int i = 0; i < 2000; i++)
            stream[i] = (i < 9) ? 1'b1 : (stream[i-9] ^ stream[i-5]);
        for (int k = 1; k <= PRBS_LEN; k++) sr[k] = stream[40 - k];
        check_eq("pkg_predict", {31'd0, prbs9_next(sr)}, {31'd0, stream[40]});

        // Reset values while rst_n is held low
        link.en = 1'b0; link.bit_in = 1'b0; link.clr_count = 1'b0;
        for (int i = 0; i < 2000; i++) flip[i] = 1'b0;
        #1;
        check_eq("rst_locked", {31'd0, link.locked}, 32'd0);
        check_eq("rst_err_pulse", {31'd0, link.err_pulse}, 32'd0);
        check_eq("rst_err_count", {16'd0, link.err_count}, 32'd0);

        // Clean lock and long error-free run
        do_reset();
        run_stream(0, 999);
        check_eq("clean_lock_idx", first_rise, 32'd24);
        check_eq("clean_err_count", {16'd0, link.err_count}, 32'd0);
        check_eq("clean_pulses", pulse_cnt, 32'd0);
        check_eq("clean_locked", {31'd0, link.locked}, 32'd1);

        // Flipped bit during VERIFY: mismatches at 12, 17, 21 delay lock to bit 37
        do_reset();
        flip[12] = 1'b1;
        run_stream(0, 60);
        check_eq("verify_lock_idx", first_rise, 32'd37);

        // Single error 100 bits after lock
        do_reset();
        flip[125] = 1'b1;
        run_stream(0, 125);
        check_eq("single_pulse_idx", last_pulse, 32'd125);
        idle(1);
        check_eq("en_low_no_pulse", {31'd0, link.err_pulse}, 32'd0);
        check_eq("en_low_hold_cnt", {16'd0, link.err_count}, 32'd1);
        run_stream(126, 399);
        check_eq("single_pulses", pulse_cnt, 32'd1);
        check_eq("single_err_count", {16'd0, link.err_count}, 32'd1);
        check_eq("single_locked", {31'd0, link.locked}, 32'd1);
        check_eq("single_drops", drop_cnt, 32'd0);

        // Burst of 8 errors in one window forces loss of lock, then relock
        do_reset();
        for (int i = 30; i <= 100; i += 10) flip[i] = 1'b1;
        run_stream(0, 99);
        check_eq("burst7_locked", {31'd0, link.locked}, 32'd1);
        run_stream(100, 100);
        check_eq("burst_drop_locked", {31'd0, link.locked}, 32'd0);
        check_eq("burst_drop_pulse", {31'd0, link.err_pulse}, 32'd1);
        check_eq("burst_err_count", {16'd0, link.err_count}, 32'd8);
        run_stream(101, 199);
        check_eq("burst_relock_idx", last_rise, 32'd125);
        check_eq("burst_pulses", pulse_cnt, 32'd8);
        check_eq("burst_err_count_kept", {16'd0, link.err_count}, 32'd8);

        // 7 errors per window, including both sides of a window boundary
        do_reset();
        base = 25;
        for (int k = 249; k <= 255; k++) flip[base + k] = 1'b1;
        for (int k = 0; k <= 6; k++) flip[base + 256 + k] = 1'b1;
        for (int k = 0; k < 7; k++) flip[base + 512 + 10 + 30 * k] = 1'b1;
        run_stream(0, base + 3 * 256 - 1);
        check_eq("win7_drops", drop_cnt, 32'd0);
        check_eq("win7_locked", {31'd0, link.locked}, 32'd1);
        check_eq("win7_err_count", {16'd0, link.err_count}, 32'd21);
        check_eq("win7_pulses", pulse_cnt, 32'd21);

        // en asserted one cycle in three: lock index in valid bits unchanged
        do_reset();
        for (int i = 0; i < 40; i++) begin
            idle(2);
            send_bit(stream[i], i);
        end
        check_eq("gap_lock_idx", first_rise, 32'd24);

        // clr_count coinciding with an error wins
        do_reset();
        flip[40] = 1'b1; flip[41] = 1'b1; flip[42] = 1'b1;
        run_stream(0, 40);
        check_eq("clr_pre_count", {16'd0, link.err_count}, 32'd1);
        link.clr_count = 1'b1;
        run_stream(41, 41);
        link.clr_count = 1'b0;
        check_eq("clr_with_err", {16'd0, link.err_count}, 32'd0);
        check_eq("clr_keeps_lock", {31'd0, link.locked}, 32'd1);
        run_stream(42, 42);
        check_eq("clr_post_count", {16'd0, link.err_count}, 32'd1);

        // All-zero input never locks
        do_reset();
        for (int i = 0; i < 500; i++) send_bit(1'b0, i);
        check_eq("zero_never_lock", first_rise, 32'hFFFF_FFFF);
        check_eq("zero_locked", {31'd0, link.locked}, 32'd0);

        // Asynchronous reset mid-stream, then relock 25 bits later
        do_reset();
        flip[40] = 1'b1; flip[50] = 1'b1;
        run_stream(0, 59);
        check_eq("mid_pre_count", {16'd0, link.err_count}, 32'd2);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst_locked", {31'd0, link.locked}, 32'd0);
        check_eq("mid_rst_count", {16'd0, link.err_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_stats();
        run_stream(60, 99);
        check_eq("mid_relock_bits", first_rise - 60 + 1, 32'd25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prbs9_checker.md
Name: prbs9_checker

Overview:
- Serial receive-side checker for the 9-bit PRBS stream x^9 + x^5 + 1 (Fibonacci form) that the team's LFSR block generates.
- Stream definition: b[n] = b[n-9] XOR b[n-5].
- Takes one bit per valid cycle, self-synchronises to the incoming sequence and declares lock.
- Once locked, predicts each bit internally and counts mismatches; drops lock on an error burst.
- Sits at the end of a link under test, opposite the PRBS9 generator.

Parameters:
- LOCK_CNT, 16, consecutive matching bits in VERIFY required to enter LOCK.
- WIN_LEN, 256, length in valid bits of the error-monitoring window while locked.
- ERR_THRESH, 8, errors within one window that force loss of lock.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  bit_in is valid this cycle; nothing advances when low.
- bit_in  in  1  received serial bit.
- clr_count  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCK.
- err_pulse  out  1  one-cycle pulse: the last valid bit mismatched while in LOCK.
- err_count  out  CNT_W  saturating count of LOCK-state mismatches.

Behaviour:
- Reset (asynchronous, rst_n low): state = HUNT; sr[1:9], seed count, match count, window count and window error count all = 0; locked = 0; err_pulse = 0; err_count = 0. Reset mid-stream discards all progress.
- All outputs are registered and update on the clk edge that samples the valid bit; they are visible the following cycle.
- sr[k] holds the valid bit received k samples ago. Predicted bit p = sr[9] XOR sr[5]. A shift puts the new bit into sr[1] and moves sr[k] to sr[k+1].
- State HUNT:
  - Each valid bit is shifted in; seed count increments.
  - On the 9th valid bit, go to VERIFY with match count = 0.
- State VERIFY (self-synchronising):
  - Compare bit_in with p, then shift bit_in itself into sr.
  - Match with sr nonzero (pre-shift): match count + 1.
  - Match with sr == 0: not counted, so an all-zero stream never locks.
  - Mismatch: match count = 0.
  - When match count reaches LOCK_CNT: go to LOCK; locked = 1; window count = 0; window error count = 0.
- State LOCK (free-running prediction):
  - Shift p, not bit_in, into sr, so a received error never propagates into later predictions.
  - On mismatch: err_pulse = 1 for one cycle; err_count + 1 (saturates at all-ones); window error count + 1.
  - Window count increments on every valid bit.
  - Threshold check on each bit: if window error count including the current bit >= ERR_THRESH, go to HUNT, locked = 0, seed count = 0. err_count is retained.
  - Window wrap: when window count reaches WIN_LEN, both window counters clear. On the last bit of a window, the threshold check runs before the clear.
- err_pulse is never asserted outside LOCK. On the bit that causes the exit to HUNT, err_pulse still pulses.
- clr_count: err_count = 0 on the next edge. When it coincides with an error, the clear wins and err_count = 0. It does not affect state or lock.
- en low: all state and counters hold; err_pulse = 0.

Decomposition:
- Package prbs9_pkg holds:
  - the state enum {HUNT, VERIFY, LOCK};
  - constants PRBS_LEN = 9, TAP_A = 9, TAP_B = 5;
  - a pure function prbs9_next(sr) that returns the predicted bit, shared with the bench reference model.
- No sub-module: a single module with one FSM and its counters.

Test Plan:
- Reset: stream locked, then rst_n pulsed low for 1 cycle mid-stream -> locked = 0 and err_count = 0 immediately; relock occurs 25 valid bits after reset release.
- Clean lock: error-free PRBS9 from seed 9'h1FF -> locked rises after the 25th valid bit (9 seed + 16 matches); err_count = 0 after 1000 bits.
- VERIFY disturbance: clean stream with valid bit index 12 (0-based) flipped -> mismatches at indices 12, 17 and 21; locked rises after the 38th valid bit.
- Single error in LOCK: one flipped bit 100 bits after lock -> exactly one err_pulse, err_count = 1, locked stays 1, no follow-on errors.
- Burst: 8 flipped bits within 200 bits after lock -> locked falls on the 8th error's cycle with err_pulse; err_count = 8; state HUNT; clean input then relocks within 25 bits. A separate run with 7 errors per 256-bit window keeps lock.
- Gaps, clear and degenerate input:
  - en toggled 1-of-3 cycles -> identical lock index counted in valid bits.
  - clr_count asserted with an error on the same edge -> err_count = 0.
  - All-zero input for 500 bits -> locked never asserts.
